// File: rtl/mac_sequencer.sv
// mac_sequencer: walks a compressed weight list (one nonzero weight + block index per entry) and
// drives MAC mask/weight/select/block_control for output channels 0..3, then drains and pulses done.
module mac_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int BLOCK_WIDTH  = 4,
  parameter int SELECT_WIDTH = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int MAC_LAT      = 2
) (
  input  logic                                Clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic                                act_valid,
  output logic                                wbuf_rd_en,
  output logic [ADDR_WIDTH-1:0]               wbuf_addr,
  input  logic [DATA_WIDTH+BLOCK_WIDTH:0]     wbuf_data,
  output logic [BLOCK_WIDTH-1:0]              mask,
  output logic [DATA_WIDTH-1:0]               weight,
  output logic [SELECT_WIDTH-1:0]             select,
  output logic                                block_control,
  output logic                                mac_en,
  output logic                                busy,
  output logic                                out_valid,
  output logic                                done
);

  localparam int EW = DATA_WIDTH + BLOCK_WIDTH + 1;
  localparam int CW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
  localparam logic [SELECT_WIDTH-1:0] LAST_CH = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [SELECT_WIDTH-1:0] chan_q, chan_d;
  logic                    first_q, first_d;
  logic                    rd_pending_q, rd_pending_d;
  logic [CW-1:0]           drain_q, drain_d;
  logic [BLOCK_WIDTH-1:0]  mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   weight_q, weight_d;
  logic [SELECT_WIDTH-1:0] select_q, select_d;
  logic                    block_control_q, block_control_d;
  logic                    mac_en_q, mac_en_d;
  logic                    busy_q, busy_d;
  logic                    out_valid_q, out_valid_d;
  logic                    done_q, done_d;

  logic                    ent_last;
  logic [BLOCK_WIDTH-1:0]  ent_idx;
  logic [DATA_WIDTH-1:0]   ent_w;
  logic                    consume, stop, rd_en, accept;

  assign ent_last = wbuf_data[EW-1];
  assign ent_idx  = wbuf_data[DATA_WIDTH+BLOCK_WIDTH-1:DATA_WIDTH];
  assign ent_w    = wbuf_data[DATA_WIDTH-1:0];

  // The last entry of the last channel must not trigger another read in its own cycle.
  assign consume = (state_q == RUN) && rd_pending_q;
  assign stop    = consume && ent_last && (chan_q == LAST_CH);
  assign rd_en   = (state_q == RUN) && act_valid && !stop;
  // A start in the done cycle belongs to the finished job and is dropped.
  assign accept  = (state_q == IDLE) && start && !done_q;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (stop) state_d = DRAIN;
      DRAIN:   if (drain_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d           = ptr_q;
    chan_d          = chan_q;
    first_d         = first_q;
    drain_d         = drain_q;
    rd_pending_d    = rd_en;
    mask_d          = mask_q;
    select_d        = select_q;
    weight_d        = '0;
    block_control_d = 1'b0;
    mac_en_d        = 1'b0;
    busy_d          = busy_q;
    out_valid_d     = 1'b0;
    done_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ptr_d   = base_addr;
          chan_d  = '0;
          first_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (rd_en) ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (consume) begin
          mask_d          = ent_idx;
          weight_d        = ent_w;
          select_d        = chan_q;
          block_control_d = first_q;
          mac_en_d        = 1'b1;
          first_d         = ent_last;
          if (ent_last) chan_d = chan_q + SELECT_WIDTH'(1);
        end
        if (stop) drain_d = CW'(MAC_LAT);
      end
      DRAIN: begin
        if (drain_q == '0) begin
          out_valid_d = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          drain_d = drain_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      ptr_q           <= '0;
      chan_q          <= '0;
      first_q         <= 1'b1;
      drain_q         <= '0;
      rd_pending_q    <= 1'b0;
      mask_q          <= '0;
      weight_q        <= '0;
      select_q        <= '0;
      block_control_q <= 1'b0;
      mac_en_q        <= 1'b0;
      busy_q          <= 1'b0;
      out_valid_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      chan_q          <= chan_d;
      first_q         <= first_d;
      drain_q         <= drain_d;
      rd_pending_q    <= rd_pending_d;
      mask_q          <= mask_d;
      weight_q        <= weight_d;
      select_q        <= select_d;
      block_control_q <= block_control_d;
      mac_en_q        <= mac_en_d;
      busy_q          <= busy_d;
      out_valid_q     <= out_valid_d;
      done_q          <= done_d;
    end
  end

  assign wbuf_rd_en    = rd_en;
  assign wbuf_addr     = ptr_q;
  assign mask          = mask_q;
  assign weight        = weight_q;
  assign select        = select_q;
  assign block_control = block_control_q;
  assign mac_en        = mac_en_q;
  assign busy          = busy_q;
  assign out_valid     = out_valid_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a weight-buffer model plus an expected op list built from each job's
// entry lists; observed MAC ops, reads and timing are compared against that list.
module tb_mac_sequencer;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int SW = 2;
  localparam int AW = 8;
  localparam int ML = 2;
  localparam int EW = DW + BW + 1;

  typedef struct packed {
    logic [BW-1:0] m;
    logic [DW-1:0] w;
    logic [SW-1:0] s;
    logic          bc;
  } op_t;

  logic          Clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          act_valid = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [EW-1:0] wbuf_data = '0;
  logic          wbuf_rd_en;
  logic [AW-1:0] wbuf_addr;
  logic [BW-1:0] mask;
  logic [DW-1:0] weight;
  logic [SW-1:0] select;
  logic          block_control, mac_en, busy, out_valid, done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [EW-1:0] mem [256];
  op_t exp_ops[$];
  op_t obs_ops[$];
  int  exp_rd[$];
  int  obs_rd[$];
  int  start_cyc, first_mac, last_mac, done_cnt, done_cyc, ov_bad, idle_w_bad, busy_bad, post_busy, timed_out;

  mac_sequencer #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .SELECT_WIDTH(SW), .ADDR_WIDTH(AW), .MAC_LAT(ML)) dut (
    .Clk(Clk), .rst(rst), .start(start), .base_addr(base_addr), .act_valid(act_valid),
    .wbuf_rd_en(wbuf_rd_en), .wbuf_addr(wbuf_addr), .wbuf_data(wbuf_data),
    .mask(mask), .weight(weight), .select(select), .block_control(block_control),
    .mac_en(mac_en), .busy(busy), .out_valid(out_valid), .done(done)
  );

  always #5 Clk = ~Clk;

  // Weight buffer: one-cycle read latency; every accepted read is logged.
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (wbuf_rd_en === 1'b1) begin
      wbuf_data <= mem[wbuf_addr];
      obs_rd.push_back(int'(wbuf_addr));
    end
  end

  task automatic build_job(input int base, input int n0, input int n1, input int n2, input int n3, input int empty_ch);
    int n;
    int k = 0;
    logic [DW-1:0] w;
    logic [BW-1:0] idx;
    logic lst;
    op_t op;
    exp_ops.delete();
    exp_rd.delete();
    for (int c = 0; c < 4; c++) begin
      n = (c == 0) ? n0 : (c == 1) ? n1 : (c == 2) ? n2 : n3;
      if (c == empty_ch) n = 1;
      for (int i = 0; i < n; i++) begin
        w   = (c == empty_ch) ? '0 : DW'($urandom_range(1, 255));
        idx = (c == empty_ch) ? BW'(5) : BW'($urandom_range(0, 15));
        lst = (i == n - 1);
        mem[(base + k) % 256] = {lst, idx, w};
        op.m = idx; op.w = w; op.s = SW'(c); op.bc = (i == 0);
        exp_ops.push_back(op);
        exp_rd.push_back((base + k) % 256);
        k++;
      end
    end
  endtask

  task automatic run_job(input int base, input int stall_at, input int start_mid, input bit start_at_done);
    int stall_cnt = 0;
    bit stalled = 0;
    bit seen_done = 0;
    int tail = 0;
    int n = 0;
    op_t op;
    obs_ops.delete(); obs_rd.delete();
    first_mac = -1; last_mac = -1; done_cnt = 0; done_cyc = -1;
    ov_bad = 0; idle_w_bad = 0; busy_bad = 0; post_busy = 0; timed_out = 0;
    @(negedge Clk);
    base_addr = AW'(base); start = 1'b1; act_valid = 1'b1;
    @(negedge Clk);
    start_cyc = cyc;
    while (tail < 5) begin
      if (mac_en === 1'b1) begin
        op.m = mask; op.w = weight; op.s = select; op.bc = block_control;
        obs_ops.push_back(op);
        if (first_mac < 0) first_mac = cyc;
        last_mac = cyc;
      end else if (busy === 1'b1 && weight !== '0) idle_w_bad++;
      if (out_valid !== done) ov_bad++;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; seen_done = 1; end
      if (seen_done) begin
        if (busy !== 1'b0) post_busy++;
      end else if (busy !== 1'b1) busy_bad++;
      start = 1'b0;
      if (start_mid >= 0 && cyc == start_cyc + start_mid) start = 1'b1;
      if (start_at_done && done === 1'b1) start = 1'b1;
      if (stall_at >= 0 && !stalled && obs_rd.size() == stall_at) begin
        act_valid = 1'b0; stall_cnt = 3; stalled = 1;
      end else if (stall_cnt > 0) begin
        stall_cnt--;
        if (stall_cnt == 0) act_valid = 1'b1;
      end
      if (seen_done) tail++;
      n++;
      if (n > 400) begin timed_out = 1; break; end
      @(negedge Clk);
    end
    start = 1'b0;
    act_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    rst = 1'b0;
    repeat (3) @(negedge Clk);
    outs = {wbuf_rd_en, wbuf_addr, mask, weight, select, block_control, mac_en, busy, out_valid, done};
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rst = 1'b1;
    repeat (2) @(negedge Clk);
    tests++;
    if (busy !== 1'b0 || wbuf_rd_en !== 1'b0) begin
      fails++; $display("FAIL reset_idle: busy=%b rd_en=%b expected 0/0", busy, wbuf_rd_en);
    end
  endtask

  task automatic test_dense();
    int bad = 0;
    build_job(16, 4, 4, 4, 4, -1);
    run_job(16, -1, -1, 0);
    tests++;
    if (timed_out != 0) begin fails++; $display("FAIL dense_timeout: done not seen"); end
    tests++;
    if (obs_rd.size() != 16) begin fails++; $display("FAIL dense_read_count: got %0d expected 16", obs_rd.size()); end
    for (int i = 0; i < exp_rd.size(); i++) if (i >= obs_rd.size() || obs_rd[i] != exp_rd[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL dense_addrs: got %0d wrong addresses expected 0", bad); end
    bad = 0;
    for (int i = 0; i < exp_ops.size(); i++) if (i >= obs_ops.size() || obs_ops[i] !== exp_ops[i]) bad++;
    tests++;
    if (bad != 0 || obs_ops.size() != exp_ops.size()) begin
      fails++; $display("FAIL dense_ops: got %0d ops %0d wrong expected %0d ops 0 wrong", obs_ops.size(), bad, exp_ops.size());
    end
    tests++;
    if (first_mac - start_cyc != 2) begin fails++; $display("FAIL dense_start_latency: got %0d expected 2", first_mac - start_cyc); end
    tests++;
    if (done_cyc - last_mac != ML + 1) begin fails++; $display("FAIL dense_done_latency: got %0d expected %0d", done_cyc - last_mac, ML + 1); end
    tests++;
    if (last_mac - first_mac + 1 != 16) begin fails++; $display("FAIL dense_no_bubbles: got span %0d expected 16", last_mac - first_mac + 1); end
    tests++;
    if (done_cnt != 1 || ov_bad != 0 || busy_bad != 0) begin
      fails++; $display("FAIL dense_done_pulse: got done=%0d ov_bad=%0d busy_bad=%0d expected 1/0/0", done_cnt, ov_bad, busy_bad);
    end
  endtask

  task automatic test_empty_channel();
    int bad = 0;
    build_job(100, 2, 3, 3, 1, 1);
    run_job(100, -1, -1, 0);
    tests++;
    if (obs_rd.size() != 7) begin fails++; $display("FAIL empty_read_count: got %0d expected 7", obs_rd.size()); end
    for (int i = 0; i < exp_ops.size(); i++) if (i >= obs_ops.size() || obs_ops[i] !== exp_ops[i]) bad++;
    tests++;
    if (bad != 0 || obs_ops.size() != exp_ops.size()) begin
      fails++; $display("FAIL empty_ops: got %0d ops %0d wrong expected %0d ops 0 wrong", obs_ops.size(), bad, exp_ops.size());
    end
    tests++;
    if (obs_ops.size() > 2 && (obs_ops[2].w !== '0 || obs_ops[2].bc !== 1'b1 || obs_ops[2].s !== SW'(1))) begin
      fails++; $display("FAIL empty_clear_op: got w=%0d bc=%b sel=%0d expected 0/1/1", obs_ops[2].w, obs_ops[2].bc, obs_ops[2].s);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    build_job(64, 4, 4, 4, 4, -1);
    run_job(64, 10, -1, 0);
    for (int i = 0; i < exp_rd.size(); i++) if (i >= obs_rd.size() || obs_rd[i] != exp_rd[i]) bad++;
    tests++;
    if (bad != 0 || obs_rd.size() != 16) begin fails++; $display("FAIL stall_addrs: got %0d reads %0d wrong expected 16 reads 0 wrong", obs_rd.size(), bad); end
    bad = 0;
    for (int i = 0; i < exp_ops.size(); i++) if (i >= obs_ops.size() || obs_ops[i] !== exp_ops[i]) bad++;
    tests++;
    if (bad != 0 || obs_ops.size() != exp_ops.size()) begin
      fails++; $display("FAIL stall_ops: got %0d ops %0d wrong expected %0d ops 0 wrong", obs_ops.size(), bad, exp_ops.size());
    end
    tests++;
    if (last_mac - first_mac + 1 - 16 != 3) begin fails++; $display("FAIL stall_gap: got %0d idle cycles expected 3", last_mac - first_mac + 1 - 16); end
    tests++;
    if (idle_w_bad != 0) begin fails++; $display("FAIL stall_weight_zero: got %0d nonzero idle weights expected 0", idle_w_bad); end
    tests++;
    if (done_cyc - last_mac != ML + 1) begin fails++; $display("FAIL stall_done_latency: got %0d expected %0d", done_cyc - last_mac, ML + 1); end
  endtask

  task automatic test_wrap();
    build_job(254, 1, 1, 1, 1, -1);
    run_job(254, -1, -1, 0);
    tests++;
    if (obs_rd.size() != 4 || obs_rd[0] != 254 || obs_rd[1] != 255 || obs_rd[2] != 0 || obs_rd[3] != 1) begin
      fails++; $display("FAIL wrap_addrs: got %0d reads first=%0d last=%0d expected 4 reads 254..1", obs_rd.size(),
                        (obs_rd.size() > 0) ? obs_rd[0] : -1, (obs_rd.size() > 0) ? obs_rd[obs_rd.size()-1] : -1);
    end
    tests++;
    if (obs_ops.size() != 4 || obs_ops[3] !== exp_ops[3]) begin fails++; $display("FAIL wrap_ops: got %0d ops expected 4 matching", obs_ops.size()); end
  endtask

  task automatic test_start_ignored();
    int bad = 0;
    build_job(200, 3, 2, 2, 3, -1);
    run_job(200, -1, 4, 1);
    for (int i = 0; i < exp_ops.size(); i++) if (i >= obs_ops.size() || obs_ops[i] !== exp_ops[i]) bad++;
    tests++;
    if (bad != 0 || obs_ops.size() != 10) begin fails++; $display("FAIL ignore_ops: got %0d ops %0d wrong expected 10 ops 0 wrong", obs_ops.size(), bad); end
    tests++;
    if (obs_rd.size() != 10) begin fails++; $display("FAIL ignore_reads: got %0d expected 10", obs_rd.size()); end
    tests++;
    if (done_cnt != 1 || post_busy != 0 || busy_bad != 0) begin
      fails++; $display("FAIL ignore_busy: got done=%0d post_busy=%0d busy_bad=%0d expected 1/0/0", done_cnt, post_busy, busy_bad);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] outs;
    int bad_idle = 0;
    int bad = 0;
    build_job(48, 4, 4, 4, 4, -1);
    @(negedge Clk);
    base_addr = AW'(48); start = 1'b1; act_valid = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #2 rst = 1'b0;
    #1 outs = {wbuf_rd_en, wbuf_addr, mask, weight, select, block_control, mac_en, busy, out_valid, done};
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL midreset_outputs: got %h expected 0", outs); end
    @(negedge Clk);
    rst = 1'b1;
    repeat (8) begin
      @(negedge Clk);
      if (done !== 1'b0 || busy !== 1'b0 || wbuf_rd_en !== 1'b0) bad_idle++;
    end
    act_valid = 1'b0;
    tests++;
    if (bad_idle != 0) begin fails++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", bad_idle); end
    build_job(48, 2, 2, 2, 2, -1);
    run_job(48, -1, -1, 0);
    for (int i = 0; i < exp_ops.size(); i++) if (i >= obs_ops.size() || obs_ops[i] !== exp_ops[i]) bad++;
    tests++;
    if (bad != 0 || obs_ops.size() != 8 || done_cnt != 1) begin
      fails++; $display("FAIL midreset_rerun: got %0d ops %0d wrong done=%0d expected 8/0/1", obs_ops.size(), bad, done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_dense();
    test_empty_channel();
    test_stall();
    test_wrap();
    test_start_ignored();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
